// File: rtl/muldiv_seq_unit_if.sv
// Operand/handshake/result bundle between the control sequencer and muldiv_seq_unit.
interface muldiv_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             MUL;
    logic             DIV;
    logic             start;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] Chigh;
    logic [WIDTH-1:0] Clow;

    modport master (
        output A, B, MUL, DIV, start,
        input  busy, done, div_zero, Chigh, Clow
    );

    modport slave (
        input  A, B, MUL, DIV, start,
        output busy, done, div_zero, Chigh, Clow
    );
endinterface

// File: rtl/muldiv_seq_unit.sv
// Multi-cycle signed multiply (radix-4 Booth) and divide (non-restoring) producing Chigh/Clow.
// Optional macro MULDIV_ZERO_BYPASS_EN: zero-operand MUL and divide-by-zero finish straight from LOAD.
module muldiv_seq_unit #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              clr,
    muldiv_seq_unit_if.slave bus
);
    localparam int HW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic signed [WIDTH-1:0] a_reg, b_reg;
    logic                    op_mul;
    logic [WIDTH-1:0]        dvs;
    logic signed [HW-1:0]    hi;
    logic [WIDTH-1:0]        lo;
    logic                    bprev;
    logic [CW-1:0]           cnt;
    logic [WIDTH-1:0]        chigh_r, clow_r;
    logic                    div_zero_r;

    logic                    accept, zero_byp, last_iter, busy, done;
    logic signed [HW-1:0]    mul_sum, dvs_x, rem_sh, rem_new;
    logic [WIDTH-1:0]        mul_hi_fix, rem_fix, res_hi, res_lo, byp_hi, byp_lo;

    function automatic logic signed [HW-1:0] booth_pp(input logic [2:0] sel,
                                                      input logic signed [WIDTH-1:0] a);
        logic signed [HW-1:0] ax;
        ax = {{2{a[WIDTH-1]}}, a};
        case (sel)
            3'b001, 3'b010: return ax;
            3'b011:         return ax <<< 1;
            3'b100:         return -(ax <<< 1);
            3'b101, 3'b110: return -ax;
            default:        return '0;
        endcase
    endfunction

    // 0x80000000 maps to unsigned 2^31, which fits the unsigned result.
    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign accept    = (state == IDLE) && bus.start && (bus.MUL || bus.DIV);
    assign last_iter = (cnt == (op_mul ? CW'(WIDTH / 2 - 1) : CW'(WIDTH - 1)));

`ifdef MULDIV_ZERO_BYPASS_EN
    assign zero_byp = op_mul ? (a_reg == '0 || b_reg == '0) : (b_reg == '0);
`else
    assign zero_byp = 1'b0;
`endif

    always_comb begin
        dvs_x      = {2'b00, dvs};
        mul_sum    = hi + booth_pp({lo[1:0], bprev}, a_reg);
        rem_sh     = {hi[HW-2:0], lo[WIDTH-1]};
        rem_new    = hi[HW-1] ? rem_sh + dvs_x : rem_sh - dvs_x;
        // Digit 16 of the sign-extended multiplier lands exactly at the current accumulator LSB.
        mul_hi_fix = WIDTH'(hi + booth_pp({b_reg[WIDTH-1], b_reg[WIDTH-1], bprev}, a_reg));
        rem_fix    = WIDTH'(hi[HW-1] ? hi + dvs_x : hi);
        res_hi     = mul_hi_fix;
        res_lo     = lo;
        if (!op_mul) begin
            if (dvs == '0) begin
                res_hi = a_reg;
                res_lo = '1;
            end else begin
                res_hi = a_reg[WIDTH-1] ? -rem_fix : rem_fix;
                res_lo = (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) ? -lo : lo;
            end
        end
        byp_hi = '0;
        byp_lo = '0;
        if (!op_mul) begin
            byp_hi = a_reg;
            byp_lo = '1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) state_nxt = LOAD;
            end
            LOAD:    state_nxt = zero_byp ? DONE : ITER;
            ITER:    if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_mul     <= 1'b0;
            dvs        <= '0;
            hi         <= '0;
            lo         <= '0;
            bprev      <= 1'b0;
            cnt        <= '0;
            chigh_r    <= '0;
            clow_r     <= '0;
            div_zero_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_reg      <= bus.A;
                    b_reg      <= bus.B;
                    op_mul     <= bus.MUL;
                    div_zero_r <= 1'b0;
                end
                LOAD: begin
                    hi    <= '0;
                    cnt   <= '0;
                    bprev <= 1'b0;
                    dvs   <= mag(b_reg);
                    lo    <= op_mul ? b_reg : mag(a_reg);
                    if (zero_byp) begin
                        chigh_r    <= byp_hi;
                        clow_r     <= byp_lo;
                        div_zero_r <= !op_mul;
                    end
                end
                ITER: begin
                    cnt <= cnt + 1'b1;
                    if (op_mul) begin
                        hi    <= mul_sum >>> 2;
                        lo    <= {mul_sum[1:0], lo[WIDTH-1:2]};
                        bprev <= lo[1];
                    end else begin
                        hi <= rem_new;
                        lo <= {lo[WIDTH-2:0], ~rem_new[HW-1]};
                    end
                end
                FIX: begin
                    chigh_r    <= res_hi;
                    clow_r     <= res_lo;
                    div_zero_r <= !op_mul && (dvs == '0);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.div_zero = div_zero_r;
    assign bus.Chigh    = chigh_r;
    assign bus.Clow     = clow_r;
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Scoreboard bench for muldiv_seq_unit: results and done timing checked against a 64-bit integer model.
module tb_muldiv_seq_unit;
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    muldiv_seq_unit_if #(.WIDTH(32)) bus ();
    muldiv_seq_unit #(.WIDTH(32)) dut (.clk(clk), .clr(clr), .bus(bus.slave));

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          done_cyc;
    } exp_t;

    exp_t scb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int lat_of(input bit m, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_ZERO_BYPASS_EN
        if (m && (a == 32'h0 || b == 32'h0)) return 2;
        if (!m && b == 32'h0) return 2;
`endif
        return m ? 19 : 35;
    endfunction

    task automatic push(input string tag, input bit m, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.tag = tag;
        e.dz  = 1'b0;
        if (m) begin
            p    = sa * sb;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'h0) begin
            e.hi = a;
            e.lo = 32'hFFFFFFFF;
            e.dz = 1'b1;
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        e.done_cyc = cyc + lat_of(m, a, b) - 1;
        scb.push_back(e);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (clr && bus.done) begin
            if (scb.size() == 0) begin
                chk("unexpected_done", bus.done, 1'b0);
            end else begin
                e = scb.pop_front();
                chk({e.tag, "_hi"}, bus.Chigh, e.hi);
                chk({e.tag, "_lo"}, bus.Clow, e.lo);
                chk({e.tag, "_dz"}, bus.div_zero, e.dz);
                chk({e.tag, "_lat"}, cyc, e.done_cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input string tag, input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.A = a; bus.B = b; bus.MUL = m; bus.DIV = d; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.MUL = 1'b0; bus.DIV = 1'b0;
        push(tag, m, a, b);
    endtask

    task automatic wait_done(input string tag);
        int          n = 0;
        bit          all_busy = 1'b1;
        bit          stable = 1'b1;
        logic [31:0] h0, l0;
        h0 = bus.Chigh;
        l0 = bus.Clow;
        while (!bus.done && n < 200) begin
            if (!bus.busy) all_busy = 1'b0;
            if (bus.Chigh !== h0 || bus.Clow !== l0) stable = 1'b0;
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, bus.done, 1'b1);
        chk({tag, "_busy"}, all_busy & bus.busy, 1'b1);
        chk({tag, "_hold"}, stable, 1'b1);
    endtask

    task automatic run(input string tag, input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        issue(tag, m, d, a, b);
        wait_done(tag);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        bit          saw;
        bit          rm;
        logic [31:0] ra, rb;
        bus.A = '0; bus.B = '0; bus.MUL = 1'b0; bus.DIV = 1'b0; bus.start = 1'b0;
        #3 clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_dz", bus.div_zero, 1'b0);
        chk("rst_hi", bus.Chigh, 32'h0);
        chk("rst_lo", bus.Clow, 32'h0);
        clr = 1'b1;
        @(negedge clk);

        run("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
        run("mul_min_min", 1'b1, 1'b0, 32'h80000000, 32'h80000000);
        run("div_m7_2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
        run("div_100_0", 1'b0, 1'b1, 32'd100, 32'd0);
        run("div_min_m1", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        run("div_m100_m7", 1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9);
        run("div_neg_by_0", 1'b0, 1'b1, 32'hFFFFFF00, 32'd0);
        run("mul_0_x", 1'b1, 1'b0, 32'd0, 32'h00001234);
        run("both_mul", 1'b1, 1'b1, 32'h00001234, 32'hFFFF0000);

        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("noop_ignored", bus.busy, 1'b0);

        issue("div_1000_7", 1'b0, 1'b1, 32'd1000, 32'd7);
        repeat (11) @(negedge clk);
        bus.A = 32'd5; bus.B = 32'd5; bus.MUL = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.MUL = 1'b0;
        wait_done("div_1000_7");
        repeat (4) @(negedge clk);
        chk("busy_start_ignored", bus.busy, 1'b0);
        chk("busy_start_scb", scb.size(), 0);

        run("b2b_first", 1'b1, 1'b0, 32'd11, 32'hFFFFFFF3);
        bus.A = 32'h0000BEEF; bus.B = 32'h00000101; bus.MUL = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        chk("b2b_not_in_done", bus.busy, 1'b0);
        @(negedge clk);
        bus.start = 1'b0; bus.MUL = 1'b0;
        push("b2b_second", 1'b1, 32'h0000BEEF, 32'h00000101);
        wait_done("b2b_second");

        issue("abort_mul", 1'b1, 1'b0, 32'h00012345, 32'h00000777);
        repeat (6) @(negedge clk);
        clr = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_hi", bus.Chigh, 32'h0);
        chk("abort_lo", bus.Clow, 32'h0);
        chk("abort_dz", bus.div_zero, 1'b0);
        scb.delete();
        @(negedge clk);
        clr = 1'b1;
        saw = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) saw = 1'b1;
        end
        chk("abort_no_done", saw, 1'b0);
        run("mul_3_3", 1'b1, 1'b0, 32'd3, 32'd3);

        for (int i = 0; i < 14; i++) begin
            rm = 1'($urandom_range(0, 1));
            ra = pick();
            rb = pick();
            run($sformatf("rnd%0d", i), rm, !rm, ra, rb);
        end

        repeat (3) @(negedge clk);
        chk("scb_drained", scb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
- Multi-cycle signed multiply/divide unit alongside the combinational ALU.
- Takes A (bus) and B (Y register) operands and produces the same 64-bit Chigh/Clow result pair that the Z register captures, for MUL and DIV.
- Multiply uses radix-4 Booth (bit-pair recoding); divide uses non-restoring division.
- The control sequencer holds the Z-load until done.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH. Only 32 is required to be supported.

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous, active-low reset
- A  in  32  operand A: multiplicand / dividend
- B  in  32  operand B: multiplier / divisor
- MUL  in  1  start signed multiply (sampled with start)
- DIV  in  1  start signed divide (sampled with start)
- start  in  1  operation request; accepted only in IDLE
- busy  out  1  high from acceptance until the done cycle, inclusive
- done  out  1  one-cycle pulse; Chigh/Clow valid from this cycle
- div_zero  out  1  set with done when a DIV had B==0; cleared on next accept
- Chigh  out  32  MUL: product[63:32]; DIV: remainder
- Clow  out  32  MUL: product[31:0]; DIV: quotient

Behaviour:
- Reset (clr=0, asynchronous): state IDLE; busy, done, div_zero, Chigh, Clow, and all internal registers are 0.
- FSM states and transitions:
  - IDLE: waits for start=1 with MUL or DIV.
  - LOAD: 1 cycle.
  - ITER: 16 cycles for MUL, 32 cycles for DIV.
  - FIX: 1 cycle.
  - DONE: 1 cycle, done=1.
  - DONE returns to IDLE.
- Acceptance: edge T with state IDLE, start=1, and MUL|DIV=1.
  - A and B are captured.
  - If both MUL and DIV are high, MUL wins.
  - start=1 with neither MUL nor DIV is ignored.
- Latency: done=1 in the cycle after the 19th edge following acceptance (MUL), or the 35th (DIV). busy=1 over the same span.
- start while busy is ignored; the operands in flight are unaffected.
- Chigh/Clow hold the last result until the next DONE. They do not change during ITER (internal working registers are separate).
- MUL:
  - Booth radix-4 over 17 recoded digits of sign-extended B, in {-2,-1,0,+1,+2}×A.
  - The digit count is handled as 16 ITER steps plus a sign-correct step in FIX.
  - Accumulation is 66 bits wide; the result is the exact two's-complement 64-bit product.
- DIV:
  - LOAD takes magnitudes of A and B. ITER runs 32 non-restoring steps.
  - FIX restores a negative remainder (add |B|) and then applies signs:
    - quotient is negated iff A[31]^B[31];
    - remainder takes the sign of A.
  - Quotient truncates toward zero.
- Boundary cases:
  - B==0 on DIV: full latency; Clow=0xFFFFFFFF, Chigh=A, div_zero=1.
  - A=0x80000000, B=0xFFFFFFFF on DIV: Clow=0x80000000, Chigh=0, div_zero=0.
  - A=0x80000000 magnitude: handled as unsigned 2^31 internally; no overflow.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done is produced for the aborted operation.
- Back-to-back: start may be re-asserted in the DONE cycle but is not accepted. It is accepted on the following cycle (IDLE).

Optional Feature:
- Macro: MULDIV_ZERO_BYPASS_EN
- Defined:
  - On MUL with A==0 or B==0, or on DIV with B==0, LOAD jumps directly to DONE.
  - done is asserted 2 edges after acceptance, with identical result values (product 0; or Q=0xFFFFFFFF, R=A, div_zero=1).
- Undefined: every operation takes the full fixed latency.

Test Plan:
- MUL, A=7, B=0xFFFFFFFD (-3) -> done after 19 edges; Chigh=0xFFFFFFFF, Clow=0xFFFFFFEB; busy high throughout.
- MUL, A=B=0x80000000 -> Chigh=0x40000000, Clow=0x00000000.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> done after 35 edges; Clow=0xFFFFFFFD, Chigh=0xFFFFFFFF; div_zero=0.
- DIV, A=100, B=0 -> Clow=0xFFFFFFFF, Chigh=100, div_zero=1. Latency is 35 edges, or 2 edges with MULDIV_ZERO_BYPASS_EN.
- DIV, A=1000, B=7, then start with MUL at iteration 10 -> second start ignored; Clow=142, Chigh=6.
- MUL in progress, clr driven low for 1 cycle at iteration 5 -> outputs 0 immediately, no done. A new MUL, A=B=3, then yields Clow=9, Chigh=0.
